hazard_controller: RTL
======================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named CLK and RESET.
REQ-002 SHALL have ports in this order (name  direction  width  meaning):
- CLK  in  1  rising-edge clock
- RESET  in  1  async active-low reset
- ID_RegisterRs1_i  in  5  rs1 of instruction in ID
- ID_RegisterRs2_i  in  5  rs2 of instruction in ID
- EX_RegDst_i  in  5  destination register held in ID/EX
- EX_MemRead_i  in  1  instruction in EX is a load (ID/EX MemtoReg bit)
- EX_Redirect_i  in  1  EX resolved a taken branch or jump
- MemBusy_i  in  1  data memory not ready this cycle
- PC_Enable  out  1  PC update enable
- IF_ID_Enable  out  1  IF/ID register enable
- IF_ID_Flush  out  1  IF/ID loads a NOP
- ID_EX_Enable  out  1  ID/EX register enable
- ID_EX_Flush  out  1  ID/EX loads zeroed control (bubble)
- EX_MEM_Enable  out  1  EX/MEM and MEM/WB enable
- StallCount  out  32  stall-cycle counter (Configuration)
- FlushCount  out  32  flush-event counter (Configuration)

Function
REQ-003 SHALL implement a registered 2-bit FSM with states RUN, FLUSH2, MEM_WAIT; all outputs are combinational functions of state and inputs.
REQ-004 SHALL define load-use hazard LU = EX_MemRead_i and EX_RegDst_i != 0 and (EX_RegDst_i == ID_RegisterRs1_i or EX_RegDst_i == ID_RegisterRs2_i).
REQ-005 Priority within any cycle SHALL be MemBusy_i > EX_Redirect_i > LU.
REQ-006 RUN, no event: all enables 1, both flushes 0; stay RUN.
REQ-007 RUN, MemBusy_i=1: all four enables 0, flushes 0 (full freeze); next MEM_WAIT.
REQ-008 MEM_WAIT: outputs as REQ-007 while MemBusy_i=1; when MemBusy_i=0, outputs as RUN with Redirect/LU evaluated per REQ-009/REQ-010 in the same cycle, next state as from RUN.
REQ-009 RUN, EX_Redirect_i=1 (no MemBusy): all enables 1, IF_ID_Flush=1, ID_EX_Flush=1; next FLUSH2.
REQ-010 RUN, LU=1 (no Redirect, no MemBusy): PC_Enable=0, IF_ID_Enable=0, ID_EX_Flush=1, EX_MEM_Enable=1, ID_EX_Enable=1; stay RUN (exactly one bubble; the bubble clears LU next cycle).
REQ-011 FLUSH2: enables 1, IF_ID_Flush=1, ID_EX_Flush=0, covers one-cycle fetch latency; next RUN; MemBusy_i=1 in FLUSH2 freezes and returns to FLUSH2 afterwards (via MEM_WAIT with remembered return flag).
REQ-012 LU and EX_Redirect_i in FLUSH2 SHALL be ignored (ID holds flushed NOP).
REQ-013 Flush SHALL dominate Enable: a flushed register loads its NOP/bubble value even if its enable is 1.
REQ-014 Rs1/Rs2 = x0 SHALL never cause a stall.

Reset
REQ-015 While RESET=0: state RUN, return flag 0, counters 0, all enables 0, all flushes 0.
REQ-016 Reset assertion mid-stall, mid-flush or mid-freeze SHALL abort immediately; first cycle after release behaves as RUN.

Configuration
REQ-017 Macro HAZARD_PERF_EN: if defined, StallCount increments on each cycle with PC_Enable=0 and RESET=1, FlushCount increments on each REQ-009 entry; both saturate at 0xFFFFFFFF.
REQ-018 Without HAZARD_PERF_EN, StallCount and FlushCount SHALL be constant 0 and no counter flops exist.

Verification
REQ-019 EX_MemRead_i=1, EX_RegDst_i=5, ID_RegisterRs2_i=5 -> one cycle PC_Enable=0, IF_ID_Enable=0, ID_EX_Flush=1; then EX_MemRead_i=0 -> RUN outputs.
REQ-020 Same as REQ-019 with EX_RegDst_i=0, Rs1=Rs2=0 -> no stall, all enables 1.
REQ-021 EX_Redirect_i pulse 1 cycle -> cycle N: IF_ID_Flush=ID_EX_Flush=1; cycle N+1: IF_ID_Flush=1 only; N+2: RUN; FlushCount=1 with macro.
REQ-022 MemBusy_i=1 for 3 cycles with EX_Redirect_i=1 and LU=1 held -> 3 cycles all enables 0; 4th cycle redirect flush, no LU bubble; StallCount=3.
REQ-023 MemBusy_i=1 during FLUSH2 for 2 cycles -> freeze 2 cycles, then one FLUSH2 cycle, then RUN.
REQ-024 RESET=0 asserted mid-FLUSH2 -> outputs all 0 immediately; after release, RUN, counters 0.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, redirect flush, memory-busy freeze.
// Optional perf counters are enabled with `define HAZARD_PERF_EN.
module hazard_controller (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_RegisterRs1_i,
  input  logic [4:0]  ID_RegisterRs2_i,
  input  logic [4:0]  EX_RegDst_i,
  input  logic        EX_MemRead_i,
  input  logic        EX_Redirect_i,
  input  logic        MemBusy_i,
  output logic        PC_Enable,
  output logic        IF_ID_Enable,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Enable,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Enable,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  typedef enum logic [1:0] {StRun, StFlush2, StMemWait} state_e;

  state_e state_q, state_d;
  logic   ret_q, ret_d;
  logic   load_use;
  logic   freeze;
  logic   do_fl2;
  logic   redirect;
  logic   lu_stall;

  assign load_use = EX_MemRead_i && (EX_RegDst_i != 5'd0) &&
                    ((EX_RegDst_i == ID_RegisterRs1_i) || (EX_RegDst_i == ID_RegisterRs2_i));

  always_comb begin
    freeze  = 1'b0;
    do_fl2  = 1'b0;
    state_d = state_q;
    ret_d   = ret_q;
    unique case (state_q)
      StRun: begin
        if (MemBusy_i) begin
          freeze  = 1'b1;
          state_d = StMemWait;
          ret_d   = 1'b0;
        end
      end
      StFlush2: begin
        if (MemBusy_i) begin
          freeze  = 1'b1;
          state_d = StMemWait;
          ret_d   = 1'b1;
        end else begin
          do_fl2  = 1'b1;
          state_d = StRun;
        end
      end
      StMemWait: begin
        if (MemBusy_i) begin
          freeze = 1'b1;
        end else if (ret_q) begin
          // The pending second flush cycle is replayed once memory is ready.
          do_fl2  = 1'b1;
          state_d = StRun;
          ret_d   = 1'b0;
        end else begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    redirect = !freeze && !do_fl2 && EX_Redirect_i;
    lu_stall = !freeze && !do_fl2 && !EX_Redirect_i && load_use;
    if (redirect) state_d = StFlush2;
  end

  always_comb begin
    PC_Enable     = RESET && !freeze && !lu_stall;
    IF_ID_Enable  = RESET && !freeze && !lu_stall;
    IF_ID_Flush   = RESET && (redirect || do_fl2);
    ID_EX_Enable  = RESET && !freeze;
    ID_EX_Flush   = RESET && (redirect || lu_stall);
    EX_MEM_Enable = RESET && !freeze;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StRun;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (!PC_Enable && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (redirect && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
    end
  end

  assign StallCount = stall_q;
  assign FlushCount = flush_q;
`else
  assign StallCount = 32'd0;
  assign FlushCount = 32'd0;
`endif

endmodule
